// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding,
// source count and the CLAIM valid-bit position.
package irq_ctrl_pkg;

    localparam int NUM_SRC         = 8;
    localparam int CLAIM_VALID_BIT = 31;

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_PEND  = 2'd1;
    localparam logic [1:0] ADDR_CLAIM = 2'd2;
    localparam logic [1:0] ADDR_EOI   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-numbered active source and
// whether any source is active at all.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] act,
    output logic [2:0]         idx,
    output logic               any
);

    // Scanning from the top down lets the lowest index overwrite the others.
    always_comb begin
        idx = '0;
        any = |act;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Eight-source, non-nesting interrupt controller with mask, edge-triggered
// pending bits and a claim/EOI handshake. Optional input synchroniser: IRQ_SYNC_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  irq,
    input  logic                we,
    input  logic                re,
    input  logic [1:0]          addr,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    output logic                int_out
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] pend_clr;
    logic [2:0]         top;
    logic [2:0]         cur;
    logic               act_any;
    logic               claim_hit;
    logic               eoi_wr;
    logic               unused_wd;
    state_t             state;
    state_t             state_n;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    assign unused_wd = ^wd[31:NUM_SRC];
    assign act       = pend & mask;
    assign pend_set  = irq_s & ~irq_q;
    assign eoi_wr    = we && (addr == ADDR_EOI);
    // A claim only counts when something is actually active to hand out.
    assign claim_hit = re && (addr == ADDR_CLAIM) && (state == ST_REQ) && act_any;
    assign int_out   = (state == ST_REQ);

    irq_prio_enc u_prio_enc (
        .act (act),
        .idx (top),
        .any (act_any)
    );

    always_comb begin
        pend_clr = '0;
        if (we && (addr == ADDR_PEND)) begin
            pend_clr = wd[NUM_SRC-1:0];
        end
        if (claim_hit) begin
            pend_clr[top] = 1'b1;
        end
    end

    // New edges are OR-ed in after the clear so a same-cycle set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
            pend  <= '0;
            mask  <= '0;
            cur   <= '0;
            state <= ST_IDLE;
        end else begin
            irq_q <= irq_s;
            pend  <= (pend & ~pend_clr) | pend_set;
            if (we && (addr == ADDR_MASK)) begin
                mask <= wd[NUM_SRC-1:0];
            end
            if (claim_hit) begin
                cur <= top;
            end
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (act_any) state_n = ST_REQ;
            ST_REQ: begin
                if (claim_hit) begin
                    state_n = ST_SVC;
                end else if (!act_any) begin
                    state_n = ST_IDLE;
                end
            end
            ST_SVC:  if (eoi_wr) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_MASK: rd[NUM_SRC-1:0] = mask;
            ADDR_PEND: rd[NUM_SRC-1:0] = pend;
            ADDR_CLAIM: begin
                if ((state == ST_REQ) && act_any) begin
                    rd[CLAIM_VALID_BIT] = 1'b1;
                    rd[2:0]             = top;
                end else begin
                    rd[2:0] = cur;
                end
            end
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-written flow/reset sequences plus a
// cycle-by-cycle vector table for priority, masking and set/clear collision.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  irq;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        int_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [7:0]  irq;
        logic [31:0] exp_rd;
        logic        exp_int;
    } vec_t;

    vec_t vq[$];

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wd      (wd),
        .rd      (rd),
        .int_out (int_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle's inputs and lets the combinational outputs settle.
    task automatic applyStimulus(input logic w, input logic r, input logic [1:0] a,
                                 input logic [31:0] d, input logic [7:0] i);
        we   = w;
        re   = r;
        addr = a;
        wd   = d;
        irq  = i;
        #3;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, expv);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, ADDR_MASK, 32'h0, 8'h00);
        tick();
        tick();
        #3;
        checkOutput("rst_int_out", {31'b0, int_out}, 32'h0);
        checkOutput("rst_mask", rd, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic addVec(input logic w, input logic r, input logic [1:0] a,
                          input logic [31:0] d, input logic [7:0] i,
                          input logic [31:0] er, input logic ei);
        vec_t v;
        v.we = w; v.re = r; v.addr = a; v.wd = d; v.irq = i;
        v.exp_rd = er; v.exp_int = ei;
        vq.push_back(v);
    endtask

    // Basic flow, EOI back to IDLE, service-time edges, and reset mid-service.
    task automatic runFlow();
        applyStimulus(1'b1, 1'b0, ADDR_MASK, 32'hFF, 8'h00);
        checkOutput("flow_int_idle", {31'b0, int_out}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_MASK, 32'h0, 8'h08);
        checkOutput("flow_mask_rd", rd, 32'hFF);
        tick();
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h08);
            checkOutput("flow_sync_pend", rd, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h08);
        checkOutput("flow_pend_set", rd, 32'h08);
        checkOutput("flow_int_lat", {31'b0, int_out}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, ADDR_CLAIM, 32'h0, 8'h08);
        checkOutput("flow_int_req", {31'b0, int_out}, 32'h1);
        checkOutput("flow_claim", rd, 32'h80000003);
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h08);
        checkOutput("flow_pend_clr", rd, 32'h0);
        checkOutput("flow_int_svc", {31'b0, int_out}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, ADDR_CLAIM, 32'h0, 8'h08);
        checkOutput("flow_svc_claim", rd, 32'h00000003);
        tick();
        applyStimulus(1'b1, 1'b0, ADDR_EOI, 32'h0, 8'h00);
        checkOutput("flow_eoi_int", {31'b0, int_out}, 32'h0);
        tick();
        for (int k = 0; k < LAT + 1; k++) begin
            applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h00);
            checkOutput("flow_idle_int", {31'b0, int_out}, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h08);
        tick();
        for (int k = 0; k < LAT; k++) tick();
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h08);
        checkOutput("flow2_pend", rd, 32'h08);
        tick();
        applyStimulus(1'b0, 1'b1, ADDR_CLAIM, 32'h0, 8'h08);
        checkOutput("flow2_int", {31'b0, int_out}, 32'h1);
        checkOutput("flow2_claim", rd, 32'h80000003);
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h48);
        tick();
        for (int k = 0; k < LAT; k++) tick();
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h48);
        checkOutput("svc_edge_pend", rd, 32'h40);
        checkOutput("svc_edge_int", {31'b0, int_out}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, ADDR_MASK, 32'h0, 8'h48);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_mask", rd, 32'h0);
        checkOutput("async_rst_int", {31'b0, int_out}, 32'h0);
        addr = ADDR_PEND;
        #1;
        checkOutput("async_rst_pend", rd, 32'h0);
        addr = ADDR_CLAIM;
        #1;
        checkOutput("async_rst_cur", rd, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h48);
        checkOutput("release_pend0", rd, 32'h0);
        tick();
        for (int k = 0; k < LAT; k++) tick();
        applyStimulus(1'b0, 1'b0, ADDR_PEND, 32'h0, 8'h48);
        checkOutput("release_pend_set", rd, 32'h48);
        checkOutput("release_int", {31'b0, int_out}, 32'h0);
        tick();
    endtask

`ifndef IRQ_SYNC_EN
    // Each row: inputs held for one cycle, outputs checked before its edge.
    task automatic runTable();
        addVec(0, 1, ADDR_CLAIM, 32'h0,        8'h00, 32'h00000000, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h00, 32'h00000000, 0);
        addVec(1, 0, ADDR_MASK,  32'hFF,       8'h00, 32'h00000000, 0);
        addVec(0, 0, ADDR_MASK,  32'h0,        8'h22, 32'h000000FF, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h22, 32'h00000022, 0);
        addVec(0, 1, ADDR_CLAIM, 32'h0,        8'h22, 32'h80000001, 1);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h22, 32'h00000020, 0);
        addVec(0, 1, ADDR_CLAIM, 32'h0,        8'h22, 32'h00000001, 0);
        addVec(1, 0, ADDR_EOI,   32'hFFFFFFFF, 8'h22, 32'h00000000, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h22, 32'h00000020, 0);
        addVec(0, 1, ADDR_CLAIM, 32'h0,        8'h22, 32'h80000005, 1);
        addVec(1, 0, ADDR_EOI,   32'h0,        8'h00, 32'h00000000, 0);
        addVec(1, 0, ADDR_MASK,  32'h0,        8'h00, 32'h000000FF, 0);
        addVec(0, 0, ADDR_MASK,  32'h0,        8'h04, 32'h00000000, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h04, 32'h00000004, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h04, 32'h00000004, 0);
        addVec(1, 0, ADDR_MASK,  32'h04,       8'h04, 32'h00000000, 0);
        addVec(0, 0, ADDR_MASK,  32'h0,        8'h04, 32'h00000004, 0);
        addVec(0, 0, ADDR_MASK,  32'h0,        8'h04, 32'h00000004, 1);
        addVec(1, 0, ADDR_PEND,  32'h04,       8'h04, 32'h00000004, 1);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h04, 32'h00000000, 1);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h00, 32'h00000000, 0);
        addVec(1, 0, ADDR_PEND,  32'h01,       8'h01, 32'h00000000, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h01, 32'h00000001, 0);
        addVec(1, 0, ADDR_PEND,  32'h01,       8'h01, 32'h00000001, 0);
        addVec(0, 0, ADDR_PEND,  32'h0,        8'h00, 32'h00000000, 0);
        foreach (vq[i]) begin
            applyStimulus(vq[i].we, vq[i].re, vq[i].addr, vq[i].wd, vq[i].irq);
            checkOutput($sformatf("vec%0d_rd", i), rd, vq[i].exp_rd);
            checkOutput($sformatf("vec%0d_int", i), {31'b0, int_out}, {31'b0, vq[i].exp_int});
            tick();
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        irq   = '0;
        we    = 1'b0;
        re    = 1'b0;
        addr  = '0;
        wd    = '0;
        doReset();
        runFlow();
`ifndef IRQ_SYNC_EN
        doReset();
        runTable();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
